// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_pkg
// Purpose  : Shared state encoding, request constants and output decode for
//            the 2-way cache control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        HIT_ACCESS = 3'd2,
        WRITE_BACK = 3'd3,
        ALLOCATE   = 3'd4,
        RESPOND    = 3'd5
    } ctrl_state_e;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef struct packed {
        logic read_en_cache;
        logic write_en_cache;
        logic read_en_mem;
        logic write_en_mem;
        logic refill;
    } ctrl_out_t;

    // Moore decode of the datapath enables for a given state.
    function automatic ctrl_out_t ctrl_decode(input ctrl_state_e state, input logic rtype);
        ctrl_out_t d;
        d = '0;
        case (state)
            HIT_ACCESS: begin
                d.read_en_cache  = (rtype == REQ_READ);
                d.write_en_cache = (rtype == REQ_WRITE);
            end
            WRITE_BACK: begin
                d.read_en_cache = 1'b1;
                d.write_en_mem  = 1'b1;
            end
            ALLOCATE: begin
                d.read_en_mem    = 1'b1;
                d.write_en_cache = 1'b1;
                d.refill         = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_timer
// Purpose  : Loadable, clearable wait counter that flags when MAX is reached.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_timer #(
    parameter int MAX   = 64,
    parameter int WIDTH = $clog2(MAX + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_inc,
    output logic                  o_timeout
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max  = (r_count == WIDTH'(MAX));
    assign o_timeout = w_at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_fsm
// Purpose  : Control FSM for the 2-way cache datapath with CPU valid/ready
//            and memory req/ack handshakes. Optional hit/miss counters are
//            built when CACHE_CTRL_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef CACHE_CTRL_PERF_EN
  , parameter int CNT_WIDTH   = 16
`endif
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic cpu_valid,
    input  wire logic cpu_req_type,
    output logic      cpu_ready,
    output logic      cpu_err,
    output logic      busy,
    input  wire logic hit,
    input  wire logic dirty_bit,
    input  wire logic mem_ack,
    output logic      req_type,
    output logic      read_en_cache,
    output logic      write_en_cache,
    output logic      read_en_mem,
    output logic      write_en_mem,
    output logic      refill
`ifdef CACHE_CTRL_PERF_EN
  , output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
`endif
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    // Timer is loaded with 1 on entry so its value equals the wait cycle number.
    localparam logic [TMR_W-1:0] c_tmr_start = TMR_W'(1);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    ctrl_out_t   w_dec;
    logic        r_retry;
    logic        w_latch, w_abort, w_set_retry;
    logic        w_tmr_clear, w_tmr_load, w_tmr_inc, w_timeout;

    cache_ctrl_timer #(
        .MAX   (MEM_TIMEOUT),
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (c_tmr_start),
        .i_inc      (w_tmr_inc),
        .o_timeout  (w_timeout)
    );

    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_abort     = 1'b0;
        w_set_retry = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_valid) begin
                    w_next  = COMPARE;
                    w_latch = 1'b1;
                end
            end
            COMPARE: begin
                if (hit) begin
                    w_next = HIT_ACCESS;
                end else if (r_retry) begin
                    w_next  = RESPOND;
                    w_abort = 1'b1;
                end else begin
                    w_next     = dirty_bit ? WRITE_BACK : ALLOCATE;
                    w_tmr_load = 1'b1;
                end
            end
            HIT_ACCESS: w_next = RESPOND;
            WRITE_BACK, ALLOCATE: begin
                // An ack arriving on the timeout cycle still completes the transfer.
                if (mem_ack) begin
                    if (r_state == WRITE_BACK) begin
                        w_next     = ALLOCATE;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_next      = COMPARE;
                        w_set_retry = 1'b1;
                        w_tmr_clear = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next      = RESPOND;
                    w_abort     = 1'b1;
                    w_tmr_clear = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_dec = ctrl_decode(w_next, req_type);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_retry        <= 1'b0;
            req_type       <= REQ_READ;
            cpu_ready      <= 1'b0;
            cpu_err        <= 1'b0;
            busy           <= 1'b0;
            read_en_cache  <= 1'b0;
            write_en_cache <= 1'b0;
            read_en_mem    <= 1'b0;
            write_en_mem   <= 1'b0;
            refill         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                req_type <= cpu_req_type;
                r_retry  <= 1'b0;
            end else if (w_set_retry) begin
                r_retry <= 1'b1;
            end
            cpu_ready      <= (w_next == RESPOND);
            cpu_err        <= w_abort;
            busy           <= (w_next != IDLE);
            read_en_cache  <= w_dec.read_en_cache;
            write_en_cache <= w_dec.write_en_cache;
            read_en_mem    <= w_dec.read_en_mem;
            write_en_mem   <= w_dec.write_en_mem;
            refill         <= w_dec.refill;
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    // Only first-pass lookups are counted; the post-refill retry is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == COMPARE && !r_retry) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl_fsm
// Purpose  : Directed self-checking bench for cache_ctrl_fsm (MEM_TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_fsm;

    localparam int MEM_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_valid = 1'b0;
    logic cpu_req_type = 1'b0;
    logic hit = 1'b0;
    logic dirty_bit = 1'b0;
    logic mem_ack = 1'b0;
    logic cpu_ready, cpu_err, busy, req_type;
    logic read_en_cache, write_en_cache, read_en_mem, write_en_mem, refill;
`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_RD_C  = 5'b10000;
    localparam logic [4:0] EN_WR_C  = 5'b01000;
    localparam logic [4:0] EN_WB    = 5'b10010;
    localparam logic [4:0] EN_ALLOC = 5'b01101;

    logic [4:0] en;
    assign en = {read_en_cache, write_en_cache, read_en_mem, write_en_mem, refill};

    cache_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_valid      (cpu_valid),
        .cpu_req_type   (cpu_req_type),
        .cpu_ready      (cpu_ready),
        .cpu_err        (cpu_err),
        .busy           (busy),
        .hit            (hit),
        .dirty_bit      (dirty_bit),
        .mem_ack        (mem_ack),
        .req_type       (req_type),
        .read_en_cache  (read_en_cache),
        .write_en_cache (write_en_cache),
        .read_en_mem    (read_en_mem),
        .write_en_mem   (write_en_mem),
        .refill         (refill)
`ifdef CACHE_CTRL_PERF_EN
      , .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] e_en,
                           input logic e_rdy, input logic e_err, input logic e_busy);
        chk({tag, ".en"},    32'(en),        32'(e_en));
        chk({tag, ".ready"}, 32'(cpu_ready), 32'(e_rdy));
        chk({tag, ".err"},   32'(cpu_err),   32'(e_err));
        chk({tag, ".busy"},  32'(busy),      32'(e_busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk_out("reset", EN_NONE, 0, 0, 0);
        chk("reset.req_type", 32'(req_type), 0);
        rst = 1'b0;
        tick();
        chk_out("idle", EN_NONE, 0, 0, 0);

        // 1: read hit, cpu_ready at cycle 3
        cpu_valid = 1; cpu_req_type = 0;
        tick();
        cpu_valid = 0; hit = 1;
        chk_out("t1_cmp", EN_NONE, 0, 0, 1);
        tick();
        chk_out("t1_hit", EN_RD_C, 0, 0, 1);
        tick();
        chk_out("t1_rsp", EN_NONE, 1, 0, 1);
        tick();
        chk_out("t1_idle", EN_NONE, 0, 0, 0);

        // 2: write hit; request input changes outside IDLE are ignored
        cpu_valid = 1; cpu_req_type = 1;
        tick();
        cpu_req_type = 0;
        chk("t2_req_type", 32'(req_type), 1);
        tick();
        cpu_valid = 0;
        chk_out("t2_hit", EN_WR_C, 0, 0, 1);
        chk("t2_req_type_hold", 32'(req_type), 1);
        tick();
        chk_out("t2_rsp", EN_NONE, 1, 0, 1);
        tick();
        chk_out("t2_idle", EN_NONE, 0, 0, 0);

        // 3: clean miss, ack on 5th ALLOCATE cycle, retry hits
        cpu_valid = 1; cpu_req_type = 0; hit = 0; dirty_bit = 0;
        tick();
        cpu_valid = 0;
        tick();
        hit = 1;
        for (int i = 0; i < 5; i++) begin
            chk_out($sformatf("t3_alloc%0d", i), EN_ALLOC, 0, 0, 1);
            if (i == 4) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        chk_out("t3_cmp", EN_NONE, 0, 0, 1);
        tick();
        chk_out("t3_hit", EN_RD_C, 0, 0, 1);
        tick();
        chk_out("t3_rsp", EN_NONE, 1, 0, 1);
        tick();

        // 4: dirty miss, 2-cycle ack in both wait states
        cpu_valid = 1; hit = 0; dirty_bit = 1;
        tick();
        cpu_valid = 0;
        tick();
        dirty_bit = 0; hit = 1;
        for (int i = 0; i < 2; i++) begin
            chk_out($sformatf("t4_wb%0d", i), EN_WB, 0, 0, 1);
            if (i == 1) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            chk_out($sformatf("t4_alloc%0d", i), EN_ALLOC, 0, 0, 1);
            if (i == 1) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        chk_out("t4_cmp", EN_NONE, 0, 0, 1);
        tick();
        chk_out("t4_hit", EN_RD_C, 0, 0, 1);
        tick();
        chk_out("t4_rsp", EN_NONE, 1, 0, 1);
        tick();

        // Retry still misses -> error response
        cpu_valid = 1; hit = 0;
        tick();
        cpu_valid = 0;
        tick();
        chk_out("tr_alloc", EN_ALLOC, 0, 0, 1);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk_out("tr_cmp", EN_NONE, 0, 0, 1);
        tick();
        chk_out("tr_rsp", EN_NONE, 1, 1, 1);
        tick();
        chk_out("tr_idle", EN_NONE, 0, 0, 0);

        // 5: no ack -> abort after MEM_TIMEOUT cycles
        cpu_valid = 1;
        tick();
        cpu_valid = 0;
        tick();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            chk_out($sformatf("t5_alloc%0d", i), EN_ALLOC, 0, 0, 1);
            tick();
        end
        chk_out("t5_rsp", EN_NONE, 1, 1, 1);
        tick();
        chk_out("t5_idle", EN_NONE, 0, 0, 0);

        // Ack on the timeout cycle wins over the abort
        cpu_valid = 1;
        tick();
        cpu_valid = 0;
        tick();
        hit = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (i == MEM_TIMEOUT - 1) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        chk_out("tw_cmp", EN_NONE, 0, 0, 1);
        tick();
        chk_out("tw_hit", EN_RD_C, 0, 0, 1);
        tick();
        chk_out("tw_rsp", EN_NONE, 1, 0, 1);
        tick();

`ifdef CACHE_CTRL_PERF_EN
        chk("perf_hit", 32'(hit_count), 2);
        chk("perf_miss", 32'(miss_count), 5);
`endif

        // 6: asynchronous reset mid-ALLOCATE
        cpu_valid = 1; hit = 0;
        tick();
        cpu_valid = 0;
        tick();
        tick();
        chk_out("t6_alloc", EN_ALLOC, 0, 0, 1);
        #1 rst = 1;
        #1;
        chk_out("t6_rst", EN_NONE, 0, 0, 0);
`ifdef CACHE_CTRL_PERF_EN
        chk("t6_hit_cnt", 32'(hit_count), 0);
        chk("t6_miss_cnt", 32'(miss_count), 0);
`endif
        tick();
        rst = 0;
        tick();
        chk_out("t6_idle", EN_NONE, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
